// File: rtl/cdb_arbiter_if.sv
// FU-side completion handshake and CDB broadcast bundle for cdb_arbiter.
// The arbiter takes the slave view; the completing side takes the master view.
interface cdb_arbiter_if #(
    parameter int N_FU     = 4,
    parameter int N_WAY    = 2,
    parameter int CDB_BITS = 6,
    parameter int XLEN     = 32
);
    localparam int PW = (N_FU > 1) ? $clog2(N_FU) : 1;

    logic [N_FU-1:0]                fu_valid;
    logic [N_FU-1:0][CDB_BITS-1:0]  fu_tag;
    logic [N_FU-1:0]                fu_is_branch;
    logic [N_FU-1:0]                fu_take_branch;
    logic [N_FU-1:0][XLEN-1:0]      fu_br_target;
    logic [N_FU-1:0]                fu_ready;
    logic [N_WAY-1:0]               cdb_valid;
    logic [N_WAY-1:0][CDB_BITS-1:0] cdb_tag;
    logic                           cdb_take_branch;
    logic [XLEN-1:0]                cdb_br_target;
    logic [PW-1:0]                  rr_ptr_o;

    modport master (
        output fu_valid, fu_tag, fu_is_branch, fu_take_branch, fu_br_target,
        input  fu_ready, cdb_valid, cdb_tag, cdb_take_branch, cdb_br_target,
        input  rr_ptr_o
    );

    modport slave (
        input  fu_valid, fu_tag, fu_is_branch, fu_take_branch, fu_br_target,
        output fu_ready, cdb_valid, cdb_tag, cdb_take_branch, cdb_br_target,
        output rr_ptr_o
    );
endinterface

// File: rtl/cdb_arbiter.sv
// Common data bus arbiter: one holding slot per FU, round-robin grant of up
// to N_WAY slots per cycle onto registered CDB lanes, at most one branch.
module cdb_arbiter #(
    parameter int N_FU     = 4,
    parameter int N_WAY    = 2,
    parameter int CDB_BITS = 6,
    parameter int XLEN     = 32
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        flush,
    cdb_arbiter_if.slave bus
);
    localparam int PW = (N_FU > 1) ? $clog2(N_FU) : 1;

    logic [N_FU-1:0]                hold_v_q, hold_v_d;
    logic [N_FU-1:0][CDB_BITS-1:0]  hold_tag_q, hold_tag_d;
    logic [N_FU-1:0]                hold_br_q, hold_br_d;
    logic [N_FU-1:0]                hold_take_q, hold_take_d;
    logic [N_FU-1:0][XLEN-1:0]      hold_tgt_q, hold_tgt_d;
    logic [PW-1:0]                  rr_ptr_q, rr_ptr_d;
    logic [N_WAY-1:0]               cdb_valid_q, cdb_valid_d;
    logic [N_WAY-1:0][CDB_BITS-1:0] cdb_tag_q, cdb_tag_d;
    logic                           cdb_take_q, cdb_take_d;
    logic [XLEN-1:0]                cdb_tgt_q, cdb_tgt_d;

    logic [N_FU-1:0]                grant;
    logic [N_WAY-1:0]               lane_v;
    logic [N_WAY-1:0][CDB_BITS-1:0] lane_tag;
    logic                           br_seen;
    logic                           br_take;
    logic [XLEN-1:0]                br_tgt;
    logic [PW-1:0]                  last;
    logic [N_FU-1:0]                fu_ready;
    int                             n_gnt;

    // Scan slots from rr_ptr with wrap; a branch is only eligible if no
    // earlier slot in scan order already took the single branch lane.
    always_comb begin
        grant    = '0;
        lane_v   = '0;
        lane_tag = '0;
        br_seen  = 1'b0;
        br_take  = 1'b0;
        br_tgt   = '0;
        last     = rr_ptr_q;
        n_gnt    = 0;
        for (int k = 0; k < N_FU; k++) begin
            for (int i = 0; i < N_FU; i++) begin
                if (i == (int'(rr_ptr_q) + k) % N_FU && hold_v_q[i] &&
                    n_gnt < N_WAY && !(hold_br_q[i] && br_seen)) begin
                    grant[i] = 1'b1;
                    for (int w = 0; w < N_WAY; w++) begin
                        if (w == n_gnt) begin
                            lane_v[w]   = 1'b1;
                            lane_tag[w] = hold_tag_q[i];
                        end
                    end
                    if (hold_br_q[i]) begin
                        br_seen = 1'b1;
                        br_take = hold_take_q[i];
                        br_tgt  = hold_tgt_q[i];
                    end
                    last  = PW'(i);
                    n_gnt = n_gnt + 1;
                end
            end
        end
    end

    always_comb begin
        fu_ready    = '0;
        hold_v_d    = hold_v_q;
        hold_tag_d  = hold_tag_q;
        hold_br_d   = hold_br_q;
        hold_take_d = hold_take_q;
        hold_tgt_d  = hold_tgt_q;
        rr_ptr_d    = rr_ptr_q;
        cdb_valid_d = lane_v;
        cdb_tag_d   = lane_tag;
        cdb_take_d  = br_take;
        cdb_tgt_d   = br_tgt;
        if (flush) begin
            hold_v_d    = '0;
            cdb_valid_d = '0;
            cdb_tag_d   = '0;
            cdb_take_d  = 1'b0;
            cdb_tgt_d   = '0;
        end else begin
            fu_ready = ~hold_v_q | grant;
            hold_v_d = hold_v_q & ~grant;
            for (int i = 0; i < N_FU; i++) begin
                if (bus.fu_valid[i] && fu_ready[i]) begin
                    // tag 0 is a no-destination completion: ack but drop
                    hold_v_d[i]    = |bus.fu_tag[i];
                    hold_tag_d[i]  = bus.fu_tag[i];
                    hold_br_d[i]   = bus.fu_is_branch[i];
                    hold_take_d[i] = bus.fu_take_branch[i];
                    hold_tgt_d[i]  = bus.fu_br_target[i];
                end
            end
            if (n_gnt != 0) begin
                rr_ptr_d = PW'((int'(last) + 1) % N_FU);
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            hold_v_q    <= '0;
            hold_tag_q  <= '0;
            hold_br_q   <= '0;
            hold_take_q <= '0;
            hold_tgt_q  <= '0;
            rr_ptr_q    <= '0;
            cdb_valid_q <= '0;
            cdb_tag_q   <= '0;
            cdb_take_q  <= 1'b0;
            cdb_tgt_q   <= '0;
        end else begin
            hold_v_q    <= hold_v_d;
            hold_tag_q  <= hold_tag_d;
            hold_br_q   <= hold_br_d;
            hold_take_q <= hold_take_d;
            hold_tgt_q  <= hold_tgt_d;
            rr_ptr_q    <= rr_ptr_d;
            cdb_valid_q <= cdb_valid_d;
            cdb_tag_q   <= cdb_tag_d;
            cdb_take_q  <= cdb_take_d;
            cdb_tgt_q   <= cdb_tgt_d;
        end
    end

    assign bus.fu_ready        = fu_ready;
    assign bus.cdb_valid       = cdb_valid_q;
    assign bus.cdb_tag         = cdb_tag_q;
    assign bus.cdb_take_branch = cdb_take_q;
    assign bus.cdb_br_target   = cdb_tgt_q;
    assign bus.rr_ptr_o        = rr_ptr_q;
endmodule

// File: tb/tb_cdb_arbiter.sv
// Bench for cdb_arbiter: directed plan cases pinned by literals, then random
// traffic compared every cycle against a slot/queue model of the arbiter.
module tb_cdb_arbiter;
    localparam int N_FU     = 4;
    localparam int N_WAY    = 2;
    localparam int CDB_BITS = 6;
    localparam int XLEN     = 32;

    logic clock = 1'b0;
    logic reset = 1'b1;
    logic flush = 1'b0;

    cdb_arbiter_if #(.N_FU(N_FU), .N_WAY(N_WAY), .CDB_BITS(CDB_BITS),
                     .XLEN(XLEN)) bus ();

    cdb_arbiter #(.N_FU(N_FU), .N_WAY(N_WAY), .CDB_BITS(CDB_BITS),
                  .XLEN(XLEN)) dut (
        .clock (clock),
        .reset (reset),
        .flush (flush),
        .bus   (bus.slave)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int failures = 0;

    // model: held completion per FU slot plus the expected CDB registers
    bit                 m_hv [N_FU];
    logic [5:0]         m_tag[N_FU];
    bit                 m_br [N_FU];
    bit                 m_tk [N_FU];
    logic [31:0]        m_tg [N_FU];
    int                 m_rr;
    logic [1:0]         e_valid;
    logic [1:0][5:0]    e_tag;
    logic               e_take;
    logic [31:0]        e_tgt;
    int                 gq[$];

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < N_FU; i++) begin
            m_hv[i] = 0; m_tag[i] = '0; m_br[i] = 0; m_tk[i] = 0; m_tg[i] = '0;
        end
        m_rr = 0; e_valid = '0; e_tag = '0; e_take = 1'b0; e_tgt = '0;
    endtask

    // rotation list of held slots, then take up to N_WAY with one branch max
    task automatic arbitrate();
        int order[$];
        bit br_used;
        gq.delete();
        br_used = 0;
        for (int off = 0; off < N_FU; off++) begin
            int s;
            s = (m_rr + off) % N_FU;
            if (m_hv[s]) order.push_back(s);
        end
        foreach (order[j]) begin
            if (gq.size() < N_WAY && !(m_br[order[j]] && br_used)) begin
                if (m_br[order[j]]) br_used = 1;
                gq.push_back(order[j]);
            end
        end
    endtask

    function automatic bit granted(input int s);
        foreach (gq[j]) if (gq[j] == s) return 1'b1;
        return 1'b0;
    endfunction

    task automatic compare();
        logic [3:0] exp_ready;
        arbitrate();
        for (int i = 0; i < N_FU; i++)
            exp_ready[i] = !flush && (!m_hv[i] || granted(i));
        chk("fu_ready", 64'(bus.fu_ready), 64'(exp_ready));
        chk("cdb_valid", 64'(bus.cdb_valid), 64'(e_valid));
        chk("cdb_tag", 64'(bus.cdb_tag), 64'(e_tag));
        chk("cdb_take", 64'(bus.cdb_take_branch), 64'(e_take));
        chk("cdb_target", 64'(bus.cdb_br_target), 64'(e_tgt));
        chk("rr_ptr", 64'(bus.rr_ptr_o), 64'(m_rr));
    endtask

    task automatic model_step();
        bit rdy[N_FU];
        if (reset) begin
            model_reset();
        end else if (flush) begin
            for (int i = 0; i < N_FU; i++) m_hv[i] = 0;
            e_valid = '0; e_tag = '0; e_take = 1'b0; e_tgt = '0;
        end else begin
            arbitrate();
            e_valid = '0; e_tag = '0; e_take = 1'b0; e_tgt = '0;
            foreach (gq[k]) begin
                e_valid[k] = 1'b1;
                e_tag[k] = m_tag[gq[k]];
                if (m_br[gq[k]]) begin e_take = m_tk[gq[k]]; e_tgt = m_tg[gq[k]]; end
            end
            if (gq.size() > 0) m_rr = (gq[gq.size()-1] + 1) % N_FU;
            for (int i = 0; i < N_FU; i++) rdy[i] = !m_hv[i] || granted(i);
            foreach (gq[k]) m_hv[gq[k]] = 0;
            for (int i = 0; i < N_FU; i++) begin
                if (bus.fu_valid[i] && rdy[i]) begin
                    m_hv[i] = (bus.fu_tag[i] != 0);
                    m_tag[i] = bus.fu_tag[i];
                    m_br[i] = bus.fu_is_branch[i];
                    m_tk[i] = bus.fu_take_branch[i];
                    m_tg[i] = bus.fu_br_target[i];
                end
            end
        end
    endtask

    task automatic step(input bit rst, input bit fl, input logic [3:0] v,
                        input logic [3:0][5:0] tg, input logic [3:0] br,
                        input logic [3:0] tk, input logic [3:0][31:0] tgt);
        @(negedge clock);
        reset = rst;
        flush = fl;
        bus.fu_valid = v;
        bus.fu_tag = tg;
        bus.fu_is_branch = br;
        bus.fu_take_branch = tk;
        bus.fu_br_target = tgt;
        #1;
        if (!rst) compare();
        model_step();
    endtask

    task automatic idle();
        step(1'b0, 1'b0, '0, '0, '0, '0, '0);
    endtask

    task automatic do_reset();
        step(1'b1, 1'b0, '0, '0, '0, '0, '0);
        step(1'b1, 1'b0, '0, '0, '0, '0, '0);
    endtask

    initial begin
        logic [3:0]       rv, rbr, rtk;
        logic [3:0][5:0]  rtg;
        logic [3:0][31:0] rtgt;
        model_reset();

        do_reset();
        idle();
        chk("rst_ready", 64'(bus.fu_ready), 64'h0f);
        chk("rst_valid", 64'(bus.cdb_valid), 64'h0);
        chk("rst_tag", 64'(bus.cdb_tag), 64'h0);
        chk("rst_rr", 64'(bus.rr_ptr_o), 64'h0);

        step(1'b0, 1'b0, 4'b0010, {6'd0, 6'd0, 6'd5, 6'd0}, '0, '0, '0);
        idle();
        idle();
        chk("single_valid", 64'(bus.cdb_valid), 64'h1);
        chk("single_tag", 64'(bus.cdb_tag), 64'h5);
        chk("single_rr", 64'(bus.rr_ptr_o), 64'h2);

        do_reset();
        step(1'b0, 1'b0, 4'b1111, {6'd4, 6'd3, 6'd2, 6'd1}, '0, '0, '0);
        idle();
        chk("full_ready", 64'(bus.fu_ready), 64'h3);
        idle();
        chk("full_c2_valid", 64'(bus.cdb_valid), 64'h3);
        chk("full_c2_tag", 64'(bus.cdb_tag), 64'({6'd2, 6'd1}));
        idle();
        chk("full_c3_tag", 64'(bus.cdb_tag), 64'({6'd4, 6'd3}));

        do_reset();
        step(1'b0, 1'b0, 4'b0111, {6'd0, 6'd9, 6'd8, 6'd7}, 4'b0011, 4'b0001,
             {32'd0, 32'd0, 32'h200, 32'h100});
        idle();
        idle();
        chk("br_c2_tag", 64'(bus.cdb_tag), 64'({6'd9, 6'd7}));
        chk("br_c2_take", 64'(bus.cdb_take_branch), 64'h1);
        chk("br_c2_target", 64'(bus.cdb_br_target), 64'h100);
        idle();
        chk("br_c3_valid", 64'(bus.cdb_valid), 64'h1);
        chk("br_c3_tag", 64'(bus.cdb_tag), 64'h8);
        chk("br_c3_take", 64'(bus.cdb_take_branch), 64'h0);
        chk("br_c3_target", 64'(bus.cdb_br_target), 64'h200);

        do_reset();
        step(1'b0, 1'b0, 4'b0011, {6'd0, 6'd0, 6'd4, 6'd3}, '0, '0, '0);
        step(1'b0, 1'b1, 4'b0100, {6'd0, 6'd6, 6'd0, 6'd0}, '0, '0, '0);
        chk("flush_ready", 64'(bus.fu_ready), 64'h0);
        idle();
        chk("flush_valid", 64'(bus.cdb_valid), 64'h0);
        chk("flush_ready_after", 64'(bus.fu_ready), 64'hf);
        for (int c = 0; c < 4; c++) begin
            idle();
            chk("flush_no_tag6", 64'(bus.cdb_valid), 64'h0);
        end

        do_reset();
        step(1'b0, 1'b0, 4'b1000, '0, '0, '0, '0);
        chk("tag0_ready", 64'(bus.fu_ready), 64'hf);
        for (int c = 0; c < 4; c++) begin
            idle();
            chk("tag0_valid", 64'(bus.cdb_valid), 64'h0);
            chk("tag0_rr", 64'(bus.rr_ptr_o), 64'h0);
        end

        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < N_FU; i++) begin
                rv[i] = ($urandom_range(0, 99) < 60);
                rtg[i] = ($urandom_range(0, 7) == 0) ? 6'd0 : 6'($urandom_range(1, 63));
                rbr[i] = ($urandom_range(0, 2) == 0);
                rtk[i] = 1'($urandom);
                rtgt[i] = $urandom;
            end
            step(($urandom_range(0, 199) == 0), ($urandom_range(0, 31) == 0),
                 rv, rtg, rbr, rtk, rtgt);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/cdb_arbiter.md
Name: cdb_arbiter

Overview:
- Arbitrates completion broadcasts from N_FU functional units onto the N_WAY common data bus lanes.
- The CDB lanes feed the ROB completion port (complete_dest_tag, take_branch, br_result) and the RS/map-table wakeup.
- Each FU has a one-entry holding slot. Slots are granted round-robin, up to N_WAY per cycle, with at most one branch per cycle, because the ROB accepts a single branch outcome per cycle.
- A flush (ROB branch_haz) discards all pending completions.

Parameters:
- N_FU, 4, number of requesting functional units
- N_WAY, 2, number of CDB lanes
- CDB_BITS, 6, physical tag width
- XLEN, 32, branch target width

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high
- flush  in  1  ROB branch_haz; discard all held and in-flight completions
- fu_valid  in  N_FU  FU presents a completion
- fu_tag  in  N_FU x CDB_BITS  destination physical tag
- fu_is_branch  in  N_FU  completion belongs to a branch
- fu_take_branch  in  N_FU  branch resolved taken
- fu_br_target  in  N_FU x XLEN  resolved branch target
- fu_ready  out  N_FU  slot can accept this cycle
- cdb_valid  out  N_WAY  lane carries a completion
- cdb_tag  out  N_WAY x CDB_BITS  broadcast tag; 0 when lane is idle
- cdb_take_branch  out  1  taken flag of the broadcast branch
- cdb_br_target  out  XLEN  target of the broadcast branch
- rr_ptr_o  out  log2(N_FU)  current round-robin start index (debug/verification)

Behaviour:
- Reset: all hold_v=0, rr_ptr=0, cdb_valid=0, cdb_tag=0, cdb_take_branch=0, cdb_br_target=0. fu_ready is all 1 in the first cycle after reset.
- Capture: a completion is accepted when fu_valid[i]&&fu_ready[i]. Slot i loads tag/is_branch/take/target at that clock edge and hold_v[i] becomes 1.
- Tag 0: a valid completion with fu_tag==0 is accepted (handshake completes) but not stored; hold_v stays 0.
- fu_ready[i] = !flush && (!hold_v[i] || grant[i]). This is combinational from registered state and the current grant.
- Arbitration: each cycle, scan held slots from rr_ptr upward with wrap-around mod N_FU, granting until N_WAY grants are made or all slots are scanned.
- Branch limit: only the first held branch slot in scan order is eligible. Later branch slots are skipped and stay held. Non-branch slots after a skipped branch remain eligible.
- Lane order: grant k drives lane k (k = 0..N_WAY-1). Unused lanes have cdb_valid=0 and tag 0.
- CDB registers: the lanes and the branch outputs load from the granted slots at the clock edge. Granted slots are cleared at the same edge unless they are re-captured.
- Latency: fu_valid accepted in cycle c gives cdb_valid in cycle c+2 at the earliest.
- Branch outputs: when no branch is granted, cdb_take_branch=0 and cdb_br_target=0 next cycle. A not-taken branch drives take_branch=0 with its target.
- Pointer: rr_ptr <= (index of last grant + 1) mod N_FU. It is unchanged when there are no grants, and it is not changed by flush.
- Back-to-back: a slot granted in cycle c may capture a new completion in the same cycle c (fu_ready=1).
- Flush: has priority over capture and grant. At the edge it clears all hold_v and all CDB outputs, so cdb_valid=0 in cycle c+1. fu_ready=0 during the flush cycle, so FU completions presented then are dropped.
- Reset mid-operation: identical to the power-up reset values; held completions are lost.
- Fairness: a continuously held slot is granted within ceil(N_FU/N_WAY)+1 cycles when no branch conflict exists.

Test Plan:
- Reset: assert reset 2 cycles -> cdb_valid=00, cdb_tag=0, rr_ptr_o=0; fu_ready=1111 in the first cycle after reset.
- Single completion: FU1 valid, tag 5, in cycle 0 -> cycle 2: cdb_valid=01, cdb_tag[0]=5; then rr_ptr_o=2.
- Full contention: FU0..3 present tags 1,2,3,4 in cycle 0 with rr_ptr=0 -> cycle 2: lanes (1,2); cycle 3: lanes (3,4). fu_ready in cycle 1 = 0011.
- Branch limit: FU0 branch tag 7 taken target 0x100, FU1 branch tag 8 not-taken, FU2 ALU tag 9 -> first broadcast: lanes (7,9), cdb_take_branch=1, cdb_br_target=0x100. Next broadcast: lane0=8, take=0.
- Flush: slots hold tags 3 and 4, flush=1 in cycle c while FU2 presents tag 6 -> cycle c+1: cdb_valid=00. Tag 6 is never broadcast, and fu_ready=1111 in cycle c+1.
- Tag zero: FU3 valid with tag 0 -> fu_ready stays 1, no broadcast ever appears, and rr_ptr is unchanged.
